// File: rtl/display_scan_controller.sv
// Scan sequencer for a 4-digit multiplexed 7-segment display: selector load strobe, dwell, blanking, frame strobe.
// Optional brightness PWM on the physical anodes is enabled with `define BRIGHTNESS_PWM_EN.
module display_scan_controller #(
    parameter int PRESCALE     = 50000,
    parameter int DWELL_TICKS  = 4,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       iClk,
    input  logic       iReset,
    input  logic       iEnable,
    input  logic [3:0] ivDigitMask,
`ifdef BRIGHTNESS_PWM_EN
    input  logic [3:0] ivBright,
`endif
    output logic [3:0] ovSelAnode,
    output logic       oCE,
    output logic [3:0] ovAnode,
    output logic       oFrame
);

    localparam int PW = $clog2(PRESCALE);
    localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    localparam logic [PW-1:0] PRE_LAST   = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SELECT = 2'd1;
    localparam logic [1:0] SHOW   = 2'd2;
    localparam logic [1:0] BLANK  = 2'd3;

    logic [1:0]    state, stateN;
    logic [1:0]    index, indexN;
    logic [PW-1:0] preCnt, preCntN;
    logic [DW-1:0] dwellCnt, dwellCntN;
    logic [BW-1:0] blankCnt, blankCntN;
    logic [3:0]    selN, anodeN;
    logic          ceN, frameN, litN;

    function automatic logic [3:0] digitCode(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    function automatic logic [1:0] lowestDigit(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (m[k]) r = 2'(k);
        end
        return r;
    endfunction

    // Rotating search from cur+1; falls back to cur itself when it is the only enabled digit.
    function automatic logic [1:0] nextDigit(input logic [1:0] cur, input logic [3:0] m);
        logic [1:0] r;
        logic [1:0] c;
        r = cur;
        for (int k = 4; k >= 1; k--) begin
            c = cur + 2'(k);
            if (m[c]) r = c;
        end
        return r;
    endfunction

`ifdef BRIGHTNESS_PWM_EN
    logic [3:0] pwmCnt, pwmCntN;
`endif

    always_comb begin
        stateN    = state;
        indexN    = index;
        preCntN   = preCnt;
        dwellCntN = dwellCnt;
        blankCntN = blankCnt;
        selN      = ovSelAnode;
        ceN       = 1'b0;
        frameN    = 1'b0;
        if (!iEnable || ivDigitMask == 4'b0000) begin
            stateN = IDLE;
            selN   = 4'b1111;
        end else begin
            case (state)
                IDLE: begin
                    indexN = lowestDigit(ivDigitMask);
                    stateN = SELECT;
                    selN   = digitCode(indexN);
                    ceN    = 1'b1;
                end
                SELECT: begin
                    preCntN   = '0;
                    dwellCntN = '0;
                    stateN    = SHOW;
                end
                SHOW: begin
                    if (!ivDigitMask[index]) begin
                        stateN    = BLANK;
                        blankCntN = '0;
                    end else if (preCnt == PRE_LAST) begin
                        preCntN = '0;
                        if (dwellCnt == DWELL_LAST) begin
                            stateN    = BLANK;
                            blankCntN = '0;
                        end else begin
                            dwellCntN = dwellCnt + 1'b1;
                        end
                    end else begin
                        preCntN = preCnt + 1'b1;
                    end
                end
                default: begin
                    if (blankCnt == BLANK_LAST) begin
                        indexN = nextDigit(index, ivDigitMask);
                        frameN = (indexN <= index);
                        stateN = SELECT;
                        selN   = digitCode(indexN);
                        ceN    = 1'b1;
                    end else begin
                        blankCntN = blankCnt + 1'b1;
                    end
                end
            endcase
        end
`ifdef BRIGHTNESS_PWM_EN
        pwmCntN = (state == SHOW && stateN == SHOW) ? pwmCnt + 4'd1 : 4'd0;
        litN    = (stateN == SHOW) && (pwmCntN < ivBright);
`else
        litN    = (stateN == SHOW);
`endif
        // Anodes follow the registered state so a digit lights only once its segments are loaded.
        anodeN = litN ? digitCode(indexN) : 4'b1111;
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state      <= IDLE;
            index      <= 2'd0;
            preCnt     <= '0;
            dwellCnt   <= '0;
            blankCnt   <= '0;
            ovSelAnode <= 4'b1111;
            ovAnode    <= 4'b1111;
            oCE        <= 1'b0;
            oFrame     <= 1'b0;
        end else begin
            state      <= stateN;
            index      <= indexN;
            preCnt     <= preCntN;
            dwellCnt   <= dwellCntN;
            blankCnt   <= blankCntN;
            ovSelAnode <= selN;
            ovAnode    <= anodeN;
            oCE        <= ceN;
            oFrame     <= frameN;
        end
    end

`ifdef BRIGHTNESS_PWM_EN
    always_ff @(posedge iClk) begin
        if (iReset) pwmCnt <= 4'd0;
        else        pwmCnt <= pwmCntN;
    end
`endif

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
- Sequences the 4-digit multiplexed 7-segment display path.
- Drives the anode code and load-enable pulse into the display selector register.
- Drives the physical anodes one cycle later, so each digit is lit only after its segment data has been registered.
- Adds dwell timing, anti-ghosting blank time, per-digit masking and a frame strobe.

Parameters:
- PRESCALE, 50000: clocks per scan tick (1 kHz at 50 MHz); minimum 2.
- DWELL_TICKS, 4: ticks each digit stays lit; minimum 1.
- BLANK_CYCLES, 16: clocks with all anodes off between digits; minimum 1.

Ports:
- iClk  in  1  system clock.
- iReset  in  1  synchronous, active-high reset.
- iEnable  in  1  scan enable; low blanks the display.
- ivDigitMask  in  4  bit n=1 means digit n participates in the scan.
- ovSelAnode  out  4  active-low one-hot code to the selector's anode input.
- oCE  out  1  one-cycle load strobe to the selector's clock enable.
- ovAnode  out  4  active-low one-hot physical anode drive.
- oFrame  out  1  one-cycle pulse when the scan wraps to a lower or equal digit index.

Behaviour:
- Clock and reset: one clock, iClk. iReset is synchronous and active-high.
- Reset values: state IDLE, digit index 0, prescaler 0, dwell counter 0, blank counter 0, ovSelAnode=4'b1111, ovAnode=4'b1111, oCE=0, oFrame=0. All outputs are registered.
- Digit code: index n maps to ~(1<<n), i.e. 0:1110, 1:1101, 2:1011, 3:0111.

State machine (IDLE, SELECT, SHOW, BLANK):
- IDLE: ovAnode=1111, ovSelAnode=1111.
  - When iEnable=1 and ivDigitMask!=0, set index to the lowest enabled digit and go to SELECT.
- SELECT: lasts exactly 1 cycle.
  - ovSelAnode=code(index), oCE=1, ovAnode=1111.
  - Clear the prescaler and dwell counter, then go to SHOW.
- SHOW: ovAnode=code(index); ovSelAnode held; oCE=0.
  - Prescaler counts 0..PRESCALE-1. At PRESCALE-1 it wraps and increments the dwell counter.
  - Leave for BLANK after exactly DWELL_TICKS*PRESCALE cycles in SHOW.
- BLANK: ovAnode=1111 for exactly BLANK_CYCLES cycles.
  - Then load index with the next enabled digit: search index+1, index+2, … modulo 4 for the first set mask bit. If only the current digit is enabled, the index is unchanged.
  - Go to SELECT. oFrame=1 in that SELECT cycle when the new index <= old index.

Latency and timing:
- Selector data is valid the cycle after oCE, which is the first SHOW cycle.
- One digit period is 1 + DWELL_TICKS*PRESCALE + BLANK_CYCLES clocks.

Boundary conditions:
- iEnable falls in any state: next state IDLE; all anodes 1111 on the next edge; no oCE or oFrame.
- ivDigitMask becomes 0: same as iEnable falling.
- Current digit's mask bit clears during SHOW: go to BLANK on the next edge (full BLANK_CYCLES), then continue with the normal next-digit search.
- Mask changes during BLANK: the next-digit search uses the mask sampled on the last BLANK cycle.
- Counters: widths are sized from the parameters using $clog2 and never overflow.
- Reset asserted mid-scan: all reset values take effect on the next edge.

Optional Feature:
- Macro: BRIGHTNESS_PWM_EN.
- When defined:
  - Adds input port ivBright (4 bits) and a 4-bit PWM counter.
  - The PWM counter increments every SHOW cycle and clears in SELECT.
  - In SHOW, ovAnode=code(index) only while pwm<ivBright, else 1111.
  - ivBright=0 keeps the display dark; ivBright=15 gives 15/16 duty.
  - SHOW duration is unchanged.
- When undefined: no ivBright port; anodes are fully on for all of SHOW.

Test Plan:
(All scenarios use PRESCALE=4, DWELL_TICKS=2, BLANK_CYCLES=3, for a 12-cycle digit period.)
- Reset, then iEnable=1, ivDigitMask=1111:
  - oCE pulses every 12 cycles.
  - ovSelAnode sequence is 1110, 1101, 1011, 0111, 1110.
  - ovAnode equals the code for 8 cycles starting 1 cycle after each oCE, followed by 1111 for 3 cycles.
  - oFrame pulses with the second 1110.
- ivDigitMask=0101: sequence is 1110, 1011, 1110; oFrame on each return to 1110; digits 1 and 3 never driven low.
- ivDigitMask=0100: oCE every 12 cycles, always 1011; oFrame on every SELECT.
- iEnable dropped mid-SHOW:
  - ovAnode=1111 the next cycle and remains so.
  - On re-enable, the first SELECT targets the lowest enabled digit.
- Mask bit of the lit digit cleared mid-SHOW: ovAnode=1111 the next cycle for 3 cycles, then the next enabled digit is selected.
- iReset pulsed mid-scan: all outputs return to reset values on the next edge; with iEnable=1 the scan restarts at digit 0. With BRIGHTNESS_PWM_EN and ivBright=4: ovAnode low for 4 of every 8 SHOW cycles (the 8-cycle SHOW is half a PWM period).
